// File: rtl/mem_access_stage.sv
// Memory stage after the ALU: one req/ack data-memory access per bundle, load alignment/extension,
// valid/ready writeback output. Define MEM_TIMEOUT_EN to abort requests after TIMEOUT_CYCLES.
module mem_access_stage
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_fault
);
  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t r_state, w_state_next;

  logic [31:0] r_dmem_addr, r_dmem_wdata, r_out_result;
  logic [3:0]  r_dmem_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd, r_out_rd;
  logic        r_dmem_we, r_is_load, r_reg_write;
  logic        r_out_valid, r_out_reg_write, r_out_fault;

  logic        w_accept, w_is_mem, w_is_load, w_is_store;
  logic        w_size_ok, w_align_ok, w_fault_in, w_start_mem, w_ack, w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load_val;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign in_ready    = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mem    = in_mem_read || in_mem_write;
  assign w_is_load   = in_mem_read;
  assign w_is_store  = !in_mem_read && in_mem_write;
  // Loads allow B/H/W/BU/HU; stores allow only the signed encodings B/H/W.
  assign w_size_ok   = w_is_load ? ((in_funct3[1:0] != 2'b11) && (in_funct3 != 3'b110))
                                 : (!in_funct3[2] && (in_funct3[1:0] != 2'b11));
  assign w_fault_in  = w_is_mem && !(w_size_ok && w_align_ok);
  assign w_start_mem = w_accept && w_is_mem && !w_fault_in;
  assign w_ack       = (r_state == S_REQ) && dmem_ack;

  always_comb begin
    w_align_ok = 1'b1;
    w_wstrb    = 4'b1111;
    w_wdata    = in_store_data;
    case (in_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << in_alu_out[1:0];
        w_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        w_align_ok = !in_alu_out[0];
        w_wstrb    = in_alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{in_store_data[15:0]}};
      end
      2'b10: w_align_ok = (in_alu_out[1:0] == 2'b00);
      default: ;
    endcase
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_tmo_cnt <= '0;
    else if (w_start_mem)                   r_tmo_cnt <= '0;
    else if (r_state == S_REQ && !dmem_ack) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Ack in the final cycle takes priority over the abort.
  assign w_timeout = (r_state == S_REQ) && !dmem_ack && (r_tmo_cnt == TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_mem) w_state_next = S_REQ;
      S_REQ:   if (w_ack || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wstrb <= '0;
      r_dmem_we    <= 1'b0;
      r_funct3     <= '0;
      r_lane       <= '0;
      r_rd         <= '0;
      r_is_load    <= 1'b0;
      r_reg_write  <= 1'b0;
    end else if (w_start_mem) begin
      r_dmem_addr  <= {in_alu_out[31:2], 2'b00};
      r_dmem_wdata <= w_wdata;
      r_dmem_wstrb <= w_is_store ? w_wstrb : 4'b0000;
      r_dmem_we    <= w_is_store;
      r_funct3     <= in_funct3;
      r_lane       <= in_alu_out[1:0];
      r_rd         <= in_rd;
      r_is_load    <= w_is_load;
      r_reg_write  <= in_reg_write;
    end
  end

  // Output registers load only on a new result, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_result    <= '0;
      r_out_rd        <= '0;
      r_out_reg_write <= 1'b0;
      r_out_fault     <= 1'b0;
    end else if (w_accept && !w_start_mem) begin
      r_out_valid     <= 1'b1;
      r_out_result    <= in_alu_out;
      r_out_rd        <= in_rd;
      r_out_reg_write <= in_reg_write && !w_fault_in;
      r_out_fault     <= w_fault_in;
    end else if (w_ack) begin
      r_out_valid     <= 1'b1;
      r_out_result    <= r_is_load ? w_load_val : 32'd0;
      r_out_rd        <= r_rd;
      r_out_reg_write <= r_is_load && r_reg_write;
      r_out_fault     <= 1'b0;
    end else if (w_timeout) begin
      r_out_valid     <= 1'b1;
      r_out_result    <= {r_dmem_addr[31:2], r_lane};
      r_out_rd        <= r_rd;
      r_out_reg_write <= 1'b0;
      r_out_fault     <= 1'b1;
    end else if (out_ready) begin
      r_out_valid     <= 1'b0;
    end
  end

  assign dmem_req      = (r_state == S_REQ);
  assign dmem_we       = r_dmem_we;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_wdata    = r_dmem_wdata;
  assign dmem_wstrb    = r_dmem_wstrb;
  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_rd        = r_out_rd;
  assign out_reg_write = r_out_reg_write;
  assign out_fault     = r_out_fault;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeback bundles and bus requests are queued
// at stimulus time and compared when the DUT presents them.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_alu_out = '0;
  logic [31:0] in_store_data = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_fault;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_out(in_alu_out),
    .in_store_data(in_store_data), .in_funct3(in_funct3), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_fault(out_fault)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
  } out_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  out_t out_q[$];
  bus_t bus_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  bit          force_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: acks ack_delay cycles after the request is first seen.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        dmem_ack = 1'b1;
      end else if (dmem_req && ack_en && !dmem_ack) begin
        if (wait_cnt >= ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = mem_rdata;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        dmem_ack = 1'b0;
        if (!dmem_req) wait_cnt = 0;
      end
    end
  end

  initial begin
    logic prev_req = 1'b0;
    bus_t b;
    forever begin
      @(negedge clk);
      if (dmem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          check_value("unexpected_req", 32'd1, 32'd0);
        end else begin
          b = bus_q.pop_front();
          check_value("bus_addr", dmem_addr, b.addr);
          check_value("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
          if (b.we) begin
            check_value("bus_wstrb", {28'd0, dmem_wstrb}, {28'd0, b.strb});
            check_value("bus_wdata", dmem_wdata, b.wdata);
          end
        end
      end
      prev_req = dmem_req;
    end
  end

  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        $display("out: result=0x%08h rd=%0d reg_write=%0b fault=%0b",
                 out_result, out_rd, out_reg_write, out_fault);
        if (out_q.size() == 0) begin
          check_value("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = out_q.pop_front();
          check_value("out_result", out_result, e.result);
          check_value("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
          check_value("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
          check_value("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
        end
      end
    end
  end

  // Drives one bundle; a mem op waits for any earlier access to finish before setting rdata.
  task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                      input logic rd_f, input logic wr_f, input logic [4:0] rd, input logic rw,
                      input logic [31:0] rdata, input logic [31:0] exp_res, input logic exp_rw,
                      input logic exp_fault, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                      input bit push_out);
    int n = 0;
    while ((bus_q.size() != 0 || dmem_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    mem_rdata = rdata;
    @(negedge clk);
    in_alu_out = alu; in_store_data = sd; in_funct3 = f3;
    in_mem_read = rd_f; in_mem_write = wr_f; in_rd = rd; in_reg_write = rw;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check_value("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (push_out) out_q.push_back('{exp_res, rd, exp_rw, exp_fault});
      if ((rd_f || wr_f) && !exp_fault)
        bus_q.push_back('{{alu[31:2], 2'b00}, !rd_f && wr_f, exp_strb, exp_wdata});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((out_q.size() != 0 || bus_q.size() != 0 || dmem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_value("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_value("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_value("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check_value("rst_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-mem pass-through, latency 1
    send(32'h1234, 0, 3'b000, 0, 0, 5'd5, 1, 0, 32'h1234, 1, 0, 0, 0, 1);
    check_value("nonmem_latency", {31'd0, out_valid}, 32'd1);
    check_value("nonmem_result", out_result, 32'h1234);

    ack_delay = 3;
    send(32'h103, 0, 3'b000, 1, 0, 5'd7, 1, 32'h80FF_0000, 32'hFFFF_FF80, 1, 0, 0, 0, 1); // LB
    send(32'h103, 0, 3'b100, 1, 0, 5'd7, 1, 32'h80FF_0000, 32'h0000_0080, 1, 0, 0, 0, 1); // LBU
    ack_delay = 0;
    send(32'h102, 0, 3'b001, 1, 0, 5'd8, 1, 32'h80FF_0000, 32'hFFFF_80FF, 1, 0, 0, 0, 1); // LH
    send(32'h102, 0, 3'b101, 1, 0, 5'd8, 1, 32'h80FF_0000, 32'h0000_80FF, 1, 0, 0, 0, 1); // LHU
    send(32'h100, 0, 3'b010, 1, 0, 5'd9, 1, 32'h80FF_0000, 32'h80FF_0000, 1, 0, 0, 0, 1); // LW
    send(32'h101, 0, 3'b000, 1, 0, 5'd9, 1, 32'h80FF_0000, 32'h0000_0000, 1, 0, 0, 0, 1); // LB lane 1
    ack_delay = 2;
    send(32'h102, 32'h1234_ABCD, 3'b001, 0, 1, 5'd3, 1, 0, 0, 0, 0, 4'b1100, 32'hABCD_ABCD, 1); // SH
    send(32'h101, 32'h0000_0055, 3'b000, 0, 1, 5'd3, 1, 0, 0, 0, 0, 4'b0010, 32'h5555_5555, 1); // SB
    send(32'h104, 32'hDEAD_BEEF, 3'b010, 0, 1, 5'd3, 0, 0, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 1); // SW
    send(32'h108, 32'h1111_1111, 3'b010, 1, 1, 5'd4, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 0, 0, 1); // read wins

    // Faults: misaligned and illegal sizes, no bus cycle
    send(32'h101, 0, 3'b010, 1, 0, 5'd6, 1, 0, 32'h101, 0, 1, 0, 0, 1);
    send(32'h103, 32'h5, 3'b001, 0, 1, 5'd6, 1, 0, 32'h103, 0, 1, 0, 0, 1);
    send(32'h200, 0, 3'b011, 1, 0, 5'd6, 1, 0, 32'h200, 0, 1, 0, 0, 1);
    send(32'h200, 0, 3'b110, 1, 0, 5'd6, 1, 0, 32'h200, 0, 1, 0, 0, 1);
    send(32'h204, 32'h7, 3'b100, 0, 1, 5'd6, 1, 0, 32'h204, 0, 1, 0, 0, 1);
    wait_idle();

    // Backpressure hold, then back-to-back drain and accept
    @(posedge clk); #1 out_ready = 1'b0;
    ack_delay = 1;
    send(32'h10C, 0, 3'b010, 1, 0, 5'd11, 1, 32'h1357_2468, 32'h1357_2468, 1, 0, 0, 0, 1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check_value("hold_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("hold_result", out_result, 32'h1357_2468);
      check_value("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_alu_out = 32'h77; in_funct3 = 3'b000; in_mem_read = 0; in_mem_write = 0;
    in_rd = 5'd12; in_reg_write = 1; in_valid = 1'b1;
    @(posedge clk); #1 out_ready = 1'b1;
    #1 check_value("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    out_q.push_back('{32'h77, 5'd12, 1'b1, 1'b0});
    @(posedge clk); #1 in_valid = 1'b0;
    check_value("b2b_valid", {31'd0, out_valid}, 32'd1);
    check_value("b2b_result", out_result, 32'h77);
    wait_idle();

    // Ack while no request is outstanding is ignored
    @(negedge clk); force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_value("idle_ack_no_out", {31'd0, out_valid}, 32'd0);
    end

    ack_en = 1'b0;
`ifdef MEM_TIMEOUT_EN
    send(32'h142, 0, 3'b001, 1, 0, 5'd13, 1, 0, 32'h142, 0, 1, 0, 0, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!dmem_req) break;
      n++;
    end
    check_value("timeout_req_cycles", n, 32'd16);
    wait_idle();
`endif

    // No ack: request held, then reset mid-REQ abandons it
    send(32'h180, 0, 3'b010, 1, 0, 5'd14, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_TIMEOUT_EN
    repeat (5) @(negedge clk);
`else
    repeat (40) @(negedge clk);
`endif
    check_value("noack_req_held", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1 check_value("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    check_value("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); force_ack = 1'b1;
    @(negedge clk); force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("late_ack_no_out", {31'd0, out_valid}, 32'd0);
      check_value("late_ack_no_req", {31'd0, dmem_req}, 32'd0);
    end
    ack_en = 1'b1;

    check_value("out_q_empty", out_q.size(), 32'd0);
    check_value("bus_q_empty", bus_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
